// File: rtl/lego_pkg.sv
// Shared types and constants for the LEGv8 fetch front end.
// Used by fetch_stage and the reusable next-PC calculator.
package lego_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_FAULT
    } fetch_state_t;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_W   = 11;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 21;
    localparam int PC_INCR    = 4;
    localparam int BR_SHIFT   = 2;

    // Instructions are word aligned; any set low bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return |pc_lsb;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next_calc.sv
// Combinational next-PC: sequential +4 or PC-relative branch (word offset << 2).
// Zero latency; no handshake. Arithmetic wraps modulo 2^ADDR_W.
module pc_next_calc
    import lego_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_src_i,
    input  logic [ADDR_W-1:0] branch_offset_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              misaligned_o
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] br_pc;

    assign seq_pc       = pc_i + ADDR_W'(PC_INCR);
    assign br_pc        = pc_i + (branch_offset_i << BR_SHIFT);
    assign next_pc_o    = pc_src_i ? br_pc : seq_pc;
    assign misaligned_o = is_misaligned(next_pc_o[1:0]);

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: holds the PC, fetches one word per step over req/ack, retires on commit.
// Fetch latency >= 1 cycle after req; next req issues the cycle after commit.
module fetch_stage
    import lego_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] op_code,
    output logic                instr_valid,
    input  logic                commit,
    input  logic                pc_src,
    input  logic [ADDR_W-1:0]   branch_offset,
    output logic [ADDR_W-1:0]   pc,
    output logic [CNT_W-1:0]    retired,
    output logic                fault
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               req_q, req_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               fault_q, fault_d;

    logic [ADDR_W-1:0]  next_pc;
    logic               next_misaligned;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc_i            (pc_q),
        .pc_src_i        (pc_src),
        .branch_offset_i (branch_offset),
        .next_pc_o       (next_pc),
        .misaligned_o    (next_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            req_q         <= 1'b0;
            retired_q     <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            req_q         <= req_d;
            retired_q     <= retired_d;
            fault_q       <= fault_d;
        end
    end

    // req is registered, so it is raised on the transition into S_REQ.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        req_d         = req_q;
        retired_d     = retired_q;
        fault_d       = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (is_misaligned(pc_q[1:0])) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    req_d         = 1'b0;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    pc_d          = next_pc;
                    retired_d     = retired_q + CNT_W'(1);
                    instr_valid_d = 1'b0;
                    if (next_misaligned) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            S_FAULT: begin
                req_d         = 1'b0;
                instr_valid_d = 1'b0;
                fault_d       = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign op_code     = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign instr_valid = instr_valid_q;
    assign retired     = retired_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: main instance at PC 0 plus a misaligned-reset instance.
module tb_fetch_stage;
    import lego_pkg::*;

    localparam int AW = 64;
    localparam int CW = 32;
    localparam logic [AW-1:0] RST_PC = 64'h0;
    localparam logic [AW-1:0] BAD_PC = 64'h2;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   instr;
    logic [10:0]   op_code;
    logic          instr_valid;
    logic          commit;
    logic          pc_src;
    logic [AW-1:0] branch_offset;
    logic [AW-1:0] pc;
    logic [CW-1:0] retired;
    logic          fault;

    logic          f_req;
    logic [AW-1:0] f_addr;
    logic [31:0]   f_instr;
    logic [10:0]   f_op;
    logic          f_valid;
    logic [AW-1:0] f_pc;
    logic [CW-1:0] f_retired;
    logic          f_fault;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(AW), .RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op_code(op_code),
        .instr_valid(instr_valid), .commit(commit), .pc_src(pc_src),
        .branch_offset(branch_offset), .pc(pc), .retired(retired), .fault(fault)
    );

    fetch_stage #(.ADDR_W(AW), .RESET_PC(BAD_PC), .CNT_W(CW)) dut_f (
        .clk(clk), .rst(rst), .imem_req(f_req), .imem_addr(f_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(f_instr), .op_code(f_op),
        .instr_valid(f_valid), .commit(commit), .pc_src(pc_src),
        .branch_offset(branch_offset), .pc(f_pc), .retired(f_retired), .fault(f_fault)
    );

    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_instr_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [AW-1:0] cur_pc;
    logic [CW-1:0] exp_ret;
    logic [31:0]   last_word;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF; commit = 1'b0;
        pc_src = 1'b0; branch_offset = '0;
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || pc !== RST_PC || instr_valid !== 1'b0 || instr !== 32'h0
            || retired !== '0 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: req=%b pc=%h valid=%b instr=%h ret=%0d fault=%b required 0,%h,0,0,0,0",
                     imem_req, pc, instr_valid, instr, retired, fault, RST_PC);
        end
        n_vec++;
        if (f_fault !== 1'b0 || f_req !== 1'b0 || f_pc !== BAD_PC) begin
            n_err++;
            $display("FAIL reset_fault_inst: fault=%b req=%b pc=%h required 0,0,%h", f_fault, f_req, f_pc, BAD_PC);
        end
        step();
        step();
        exp_addr_q.delete();
        exp_instr_q.delete();
        exp_addr_q.push_back(RST_PC);
        cur_pc = RST_PC; exp_ret = '0; last_word = '0;
        // Late ack and a commit land in the S_IDLE cycle: both must be ignored.
        rst = 1'b0; commit = 1'b1; pc_src = 1'b1; branch_offset = 64'h10;
        step();
        commit = 1'b0; imem_ack = 1'b0; pc_src = 1'b0; branch_offset = '0;
        n_vec++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || retired !== '0 || pc !== RST_PC || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ignore: valid=%b instr=%h ret=%0d pc=%h req=%b required 0,0,0,%h,1",
                     instr_valid, instr, retired, pc, imem_req, RST_PC);
        end
    endtask

    task automatic do_fetch(input logic [31:0] word, input int delay);
        int waited = 0;
        logic [AW-1:0] a0;
        logic [AW-1:0] ea;
        logic [31:0] ew;
        while (imem_req !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_vec++;
        if (imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_req_timeout: imem_req=%b required 1", imem_req);
            return;
        end
        n_vec++;
        if (exp_addr_q.size() == 0) begin
            n_err++;
            $display("FAIL fetch_addr: addr=%h required <none queued>", imem_addr);
        end else begin
            ea = exp_addr_q.pop_front();
            if (imem_addr !== ea) begin
                n_err++;
                $display("FAIL fetch_addr: addr=%h required %h", imem_addr, ea);
            end
        end
        a0 = imem_addr;
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            step();
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== a0 || instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL fetch_wait: req=%b addr=%h valid=%b required 1,%h,0", imem_req, imem_addr, instr_valid, a0);
            end
        end
        imem_ack = 1'b1; imem_rdata = word;
        exp_instr_q.push_back(word);
        step();
        imem_ack = 1'b0; imem_rdata = 32'h0BAD_F00D;
        n_vec++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_capture: valid=%b req=%b required 1,0", instr_valid, imem_req);
        end
        ew = exp_instr_q.pop_front();
        n_vec++;
        if (instr !== ew) begin
            n_err++;
            $display("FAIL fetch_instr: instr=%h required %h", instr, ew);
        end
        n_vec++;
        if (op_code !== ew[31:21]) begin
            n_err++;
            $display("FAIL fetch_opcode: op_code=%b required %b", op_code, ew[31:21]);
        end
        last_word = ew;
    endtask

    task automatic do_commit(input logic src, input logic [AW-1:0] off, input logic [AW-1:0] exp_next,
                             input int hold, input logic spurious);
        for (int i = 0; i < hold; i++) begin
            imem_ack = spurious; imem_rdata = 32'hDEAD_BEEF; pc_src = i[0];
            branch_offset = 64'hFFFF; commit = 1'b0;
            step();
            n_vec++;
            if (instr !== last_word || instr_valid !== 1'b1 || pc !== cur_pc || retired !== exp_ret || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL exec_hold: instr=%h valid=%b pc=%h ret=%0d req=%b required %h,1,%h,%0d,0",
                         instr, instr_valid, pc, retired, imem_req, last_word, cur_pc, exp_ret);
            end
        end
        imem_ack = 1'b0; commit = 1'b1; pc_src = src; branch_offset = off;
        exp_addr_q.push_back(exp_next);
        exp_ret = exp_ret + 1'b1;
        step();
        commit = 1'b0; pc_src = 1'b0; branch_offset = '0;
        n_vec++;
        if (pc !== exp_next) begin
            n_err++;
            $display("FAIL commit_pc: pc=%h required %h", pc, exp_next);
        end
        n_vec++;
        if (retired !== exp_ret) begin
            n_err++;
            $display("FAIL commit_retired: retired=%0d required %0d", retired, exp_ret);
        end
        n_vec++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || instr !== last_word) begin
            n_err++;
            $display("FAIL commit_b2b: valid=%b req=%b instr=%h required 0,1,%h", instr_valid, imem_req, instr, last_word);
        end
        cur_pc = exp_next;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_sequential();
        logic [31:0] words [4];
        words[0] = 32'h8B00_0000;
        words[1] = 32'hCB00_0000;
        words[2] = 32'hF840_0000;
        words[3] = 32'hB400_0040;
        for (int i = 0; i < 4; i++) begin
            do_fetch(words[i], 0);
            if (i == 0) begin
                n_vec++;
                if (op_code !== 11'b10001011000) begin
                    n_err++;
                    $display("FAIL add_opcode: op_code=%b required 10001011000", op_code);
                end
            end
            do_commit(1'b0, '0, 64'(4 * (i + 1)), 1, 1'b0);
        end
        n_vec++;
        if (retired !== 32'd4) begin
            n_err++;
            $display("FAIL seq_retired: retired=%0d required 4", retired);
        end
    endtask

    task automatic test_commit_gating();
        for (int i = 0; i < 3; i++) begin
            commit = 1'b1; pc_src = i[0]; branch_offset = 64'h100;
            step();
            commit = 1'b0;
            n_vec++;
            if (pc !== 64'h10 || retired !== 32'd4 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL commit_in_req: pc=%h ret=%0d req=%b valid=%b required 10,4,1,0",
                         pc, retired, imem_req, instr_valid);
            end
        end
        pc_src = 1'b0; branch_offset = '0;
        do_fetch(32'h9100_0421, 0);
        do_commit(1'b0, '0, 64'h14, 4, 1'b0);
    endtask

    task automatic test_wait_states();
        do_fetch(32'hAA00_03E0, 3);
        do_commit(1'b0, '0, 64'h18, 3, 1'b1);
    endtask

    task automatic test_branch_wrap();
        do_fetch(32'h1400_000A, 0);
        do_commit(1'b1, 64'hA, 64'h40, 0, 1'b0);
        do_fetch(32'h17FF_FFFF, 1);
        do_commit(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h30, 1, 1'b0);
        do_fetch(32'h17FF_FFF3, 0);
        do_commit(1'b1, 64'hFFFF_FFFF_FFFF_FFF3, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1'b0);
        do_fetch(32'hD503_201F, 0);
        do_commit(1'b0, '0, 64'h0, 0, 1'b0);
        do_fetch(32'h8B01_0000, 0);
    endtask

    task automatic test_reset_mid_fetch();
        logic [AW-1:0] ea;
        do_commit(1'b0, '0, 64'h4, 0, 1'b0);
        ea = exp_addr_q.pop_front();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== ea) begin
            n_err++;
            $display("FAIL midfetch_pre: req=%b addr=%h required 1,%h", imem_req, imem_addr, ea);
        end
        apply_reset();
        do_fetch(32'h8B02_0000, 1);
        do_commit(1'b0, '0, 64'h4, 0, 1'b0);
        do_fetch(32'hCB03_0000, 0);
    endtask

    task automatic test_fault();
        apply_reset();
        n_vec++;
        if (f_fault !== 1'b1 || f_req !== 1'b0 || f_valid !== 1'b0 || f_pc !== BAD_PC) begin
            n_err++;
            $display("FAIL fault_entry: fault=%b req=%b valid=%b pc=%h required 1,0,0,%h",
                     f_fault, f_req, f_valid, f_pc, BAD_PC);
        end
        for (int i = 0; i < 8; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'h1234_5678; commit = i[0]; pc_src = i[1];
            branch_offset = 64'h4;
            step();
            n_vec++;
            if (f_req !== 1'b0 || f_fault !== 1'b1 || f_retired !== '0 || f_addr !== BAD_PC
                || f_valid !== 1'b0 || f_instr !== 32'h0 || f_op !== 11'h0) begin
                n_err++;
                $display("FAIL fault_hold: req=%b fault=%b ret=%0d addr=%h valid=%b instr=%h op=%h required 0,1,0,%h,0,0,0",
                         f_req, f_fault, f_retired, f_addr, f_valid, f_instr, f_op, BAD_PC);
            end
        end
        imem_ack = 1'b0; commit = 1'b0; pc_src = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if (f_fault !== 1'b0) begin
            n_err++;
            $display("FAIL fault_clear: fault=%b required 0", f_fault);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        imem_ack = 1'b0; imem_rdata = '0; commit = 1'b0; pc_src = 1'b0; branch_offset = '0;
        test_reset();
        test_sequential();
        test_commit_gating();
        test_wait_states();
        test_branch_wrap();
        test_reset_mid_fetch();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage upstream of the control unit.
- Holds the PC and fetches one 32-bit LEGv8 instruction per step from instruction memory through a req/ack handshake.
- Presents the instruction and its 11-bit op_code field to decode/control.
- Consumes the control unit's pc_src and the sign-extended branch offset to choose the next PC when the downstream datapath commits the current instruction.

Parameters:
- ADDR_W, 64, width of PC and instruction-memory address.
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  byte address of the fetch; equals pc.
- imem_ack  input  1  memory response valid; qualifies imem_rdata.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  registered instruction currently held for execute.
- op_code  output  11  instr[31:21], straight slice of instr.
- instr_valid  output  1  instr holds a fetched, uncommitted instruction.
- commit  input  1  downstream finished the current instruction this cycle.
- pc_src  input  1  from the control unit: 1 = take branch.
- branch_offset  input  ADDR_W  sign-extended word offset from the sign-extend unit.
- pc  output  ADDR_W  address of the current or pending instruction.
- retired  output  CNT_W  count of committed instructions.
- fault  output  1  sticky misaligned-PC fault.

Behaviour:
- Reset (async, immediate): state=S_IDLE, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, retired=0, fault=0.
- States: S_IDLE, S_REQ, S_EXEC, S_FAULT.
- S_IDLE: one cycle after reset release, then check alignment.
  - pc[1:0]!=0 -> S_FAULT.
  - Otherwise -> S_REQ.
- S_REQ: imem_req=1 (registered, asserted from the first cycle in the state).
  - imem_addr is held stable until the ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, -> S_EXEC.
  - Fetch latency is therefore 1 cycle minimum, unbounded otherwise.
- S_EXEC: hold instr, instr_valid=1, pc unchanged, until commit=1. On commit:
  - pc <= pc_src ? pc + (branch_offset << 2) : pc + 4.
  - Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
  - retired <= retired + 1, wrapping at 2^CNT_W.
  - instr_valid <= 0.
  - Next state: S_FAULT if the new pc is misaligned, else S_REQ.
  - instr keeps its old value until the next ack.
- S_FAULT: imem_req=0, instr_valid=0, fault=1. Held until reset; commit and imem_ack are ignored.
- imem_ack while imem_req=0 (any state other than S_REQ): ignored; no capture, no state change.
- commit outside S_EXEC: ignored; pc and retired unchanged.
- pc_src and branch_offset are sampled only in the cycle where commit=1 in S_EXEC.
- The back-to-back path is commit in cycle N -> imem_req high in cycle N+1 with the new address.
- Reset mid-fetch: req drops asynchronously; a late ack after reset release, seen in S_IDLE, is ignored.
- op_code is combinational from instr (no extra latency). All other outputs are registered.

Decomposition:
- Shared package lego_pkg:
  - State enum fetch_state_t (S_IDLE, S_REQ, S_EXEC, S_FAULT).
  - INSTR_W=32, OPCODE_W=11, OPCODE_MSB=31, OPCODE_LSB=21.
  - PC_INCR=4, BR_SHIFT=2.
- One natural sub-module, pc_next_calc: combinational next-PC adder/mux (pc, pc_src, branch_offset -> next_pc, misaligned flag). It is reused by a later pipelined version.
- The FSM, registers and counter live in fetch_stage.

Test Plan:
- Sequential fetch: reset with RESET_PC=0, memory acks 1 cycle after req, commit each instruction with pc_src=0 -> imem_addr sequence 0,4,8,12; retired=4; op_code = word[31:21]. For ADD 0x8B000000, op_code=11'b10001011000.
- Memory wait states: ack delayed 3 cycles, with spurious acks while req=0 -> instr_valid rises only on the real ack; imem_addr stable throughout; spurious acks cause no capture.
- Branches and wrap: at pc=0x40 commit with pc_src=1, branch_offset=-4 (all ones ...FFFC) -> next imem_addr=0x30. At pc=0xFFFF_FFFF_FFFF_FFFC commit with pc_src=0 -> imem_addr=0.
- Commit gating: commit pulsed in S_REQ and S_IDLE, and pc_src toggled with commit=0 -> pc and retired unchanged.
- Async reset mid-fetch: assert rst while imem_req=1 and ack pending -> imem_req=0 in the same cycle, pc=RESET_PC; ack arriving in S_IDLE is ignored; fetch resumes at RESET_PC.
- Fault: RESET_PC=0x2 -> fault=1 after the S_IDLE cycle, imem_req never asserts, held until reset.
